// File: rtl/mc_ctrl_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and the enables/selects back to it.
// master = control unit, slave = datapath side.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             PCWr;
  logic             IRWr;
  logic [1:0]       nPC_sel;
  logic             RegWr;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic             ExtOp;
  logic             ALUSrc;
  logic [2:0]       ALUctr;
  logic             MemRd;
  logic             MemWr;
  logic             illegal;
  logic             mem_fault;
  logic [CNT_W-1:0] instret;

  modport master (
    input  ins, zero, mem_ready,
    output PCWr, IRWr, nPC_sel, RegWr, RegDst, MemtoReg, ExtOp, ALUSrc, ALUctr,
           MemRd, MemWr, illegal, mem_fault, instret
  );

  modport slave (
    output ins, zero, mem_ready,
    input  PCWr, IRWr, nPC_sel, RegWr, RegDst, MemtoReg, ExtOp, ALUSrc, ALUctr,
           MemRd, MemWr, illegal, mem_fault, instret
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB): combinational per-state enables,
// MEM waits on mem_ready with a timeout, retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [5:0] op, funct;
  logic       is_r, is_jr, is_jump, is_lw, is_sw, is_beq, legal, mem_to, retire;
  logic [2:0] alu_op;
  logic       alu_src, ext_op;

  assign op      = bus.ins[31:26];
  assign funct   = bus.ins[5:0];
  assign is_r    = (op == OP_R);
  assign is_jr   = is_r && (funct == F_JR);
  assign is_jump = (op == OP_J) || (op == OP_JAL) || is_jr;
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign legal   = is_jump || is_lw || is_sw || is_beq || (op == OP_ORI) || (op == OP_LUI) ||
                   (is_r && (funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLT}));

  // Timeout only on the MEM_TIMEOUT-th not-ready cycle; a ready in that cycle still completes.
  assign mem_to  = (state_q == S_MEM) && !bus.mem_ready && (wait_q == TO_LAST);

  // ALU controls follow the instruction through EX/MEM/WB so the address stays stable.
  always_comb begin
    alu_op  = ALU_PASS;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADDU:  alu_op = 3'b000;
          F_SUBU:  alu_op = 3'b001;
          F_OR:    alu_op = 3'b010;
          F_AND:   alu_op = 3'b110;
          F_SLT:   alu_op = 3'b101;
          default: alu_op = ALU_PASS;
        endcase
      end
      OP_ORI: begin alu_op = 3'b010; alu_src = 1'b1; end
      OP_LUI: begin alu_op = 3'b011; alu_src = 1'b1; end
      OP_LW, OP_SW: begin alu_op = 3'b000; alu_src = 1'b1; ext_op = 1'b1; end
      OP_BEQ: alu_op = 3'b001;
      default: alu_op = ALU_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = S_IF;
    wait_d  = 8'd0;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        state_d = (legal && !is_jump) ? S_EX : S_IF;
        retire  = is_jump;
      end
      S_EX: begin
        state_d = (is_lw || is_sw) ? S_MEM : (is_beq ? S_IF : S_WB);
        retire  = is_beq;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = is_lw ? S_WB : S_IF;
          retire  = is_sw;
        end else if (!mem_to) begin
          state_d = S_MEM;
          wait_d  = wait_q + 8'd1;
        end
      end
      S_WB: retire = 1'b1;
      default: state_d = S_IF;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  assign bus.instret = instret_q;

  always_comb begin
    bus.PCWr      = 1'b0;
    bus.IRWr      = 1'b0;
    bus.nPC_sel   = 2'b00;
    bus.RegWr     = 1'b0;
    bus.RegDst    = 2'b00;
    bus.MemtoReg  = 2'b00;
    bus.ExtOp     = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.ALUctr    = ALU_PASS;
    bus.MemRd     = 1'b0;
    bus.MemWr     = 1'b0;
    bus.illegal   = 1'b0;
    bus.mem_fault = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          bus.PCWr = 1'b1;
          bus.IRWr = 1'b1;
        end
        S_ID: begin
          if (!legal) begin
            bus.illegal = 1'b1;
          end else if (is_jr) begin
            bus.PCWr    = 1'b1;
            bus.nPC_sel = 2'b11;
          end else if (is_jump) begin
            bus.PCWr    = 1'b1;
            bus.nPC_sel = 2'b10;
            if (op == OP_JAL) begin
              bus.RegWr    = 1'b1;
              bus.RegDst   = 2'b10;
              bus.MemtoReg = 2'b10;
            end
          end
        end
        S_EX, S_MEM, S_WB: begin
          bus.ALUctr = alu_op;
          bus.ALUSrc = alu_src;
          bus.ExtOp  = ext_op;
          if (state_q == S_EX && is_beq) begin
            bus.nPC_sel = 2'b01;
            bus.PCWr    = bus.zero;
          end
          if (state_q == S_MEM) begin
            bus.MemRd     = is_lw && !mem_to;
            bus.MemWr     = is_sw && !mem_to;
            bus.mem_fault = mem_to;
          end
          if (state_q == S_WB) begin
            bus.RegWr    = 1'b1;
            bus.RegDst   = is_r ? 2'b01 : 2'b00;
            bus.MemtoReg = is_lw ? 2'b01 : 2'b00;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboarded bench for mc_ctrl: per-cycle expected control vectors are queued with their
// stimulus and compared at the falling edge; a second 4-bit-counter instance covers wrap.
module tb_mc_ctrl;
  logic clk;
  logic rst;
  logic rst_w;

  mc_ctrl_if #(.CNT_W(32)) bus ();
  mc_ctrl_if #(.CNT_W(4))  bw ();

  mc_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15)) u_dut (.clk(clk), .rst(rst),   .bus(bus));
  mc_ctrl #(.CNT_W(4),  .MEM_TIMEOUT(15)) u_w   (.clk(clk), .rst(rst_w), .bus(bw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwr;
    logic       irwr;
    logic [1:0] npc;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       ext;
    logic       src;
    logic [2:0] alu;
    logic       memrd;
    logic       memwr;
    logic       ill;
    logic       mf;
  } ctl_t;

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic        r;
    logic        z;
    logic        rdy;
    ctl_t        val;
    ctl_t        msk;
    logic        chk;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;
  ctl_t obs;
  ctl_t m_all, m_base, m_imm;

  assign obs = {bus.PCWr, bus.IRWr, bus.nPC_sel, bus.RegWr, bus.RegDst, bus.MemtoReg, bus.ExtOp,
                bus.ALUSrc, bus.ALUctr, bus.MemRd, bus.MemWr, bus.illegal, bus.mem_fault};

  function automatic ctl_t ctl(logic pc, logic ir, logic [1:0] npc, logic rw, logic [1:0] rd,
                               logic [1:0] m2r, logic ext, logic src, logic [2:0] alu,
                               logic mr, logic mw, logic ill, logic mf);
    return {pc, ir, npc, rw, rd, m2r, ext, src, alu, mr, mw, ill, mf};
  endfunction

  task automatic push(string tag, logic [31:0] ins, ctl_t v, ctl_t m, logic r, logic z,
                      logic rdy, logic chk);
    exp_t e;
    e.tag = tag; e.ins = ins; e.r = r; e.z = z; e.rdy = rdy;
    e.val = v; e.msk = m; e.chk = chk; e.n = n_ret;
    sb.push_back(e);
  endtask

  task automatic push_if(string tag, logic [31:0] ins, logic rdy);
    push({tag, "_if"}, ins, ctl(1,1,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,0,0), m_base, 0, 0, rdy, 1);
  endtask

  task automatic push_id0(string tag, logic [31:0] ins, logic rdy);
    push({tag, "_id"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,0,0), m_base, 0, 0, rdy, 0);
  endtask

  task automatic do_r(string tag, logic [31:0] ins, logic [2:0] alu);
    push_if(tag, ins, 0);
    push_id0(tag, ins, 0);
    push({tag, "_ex"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,alu,0,0,0,0), m_all, 0, 0, 0, 0);
    push({tag, "_wb"}, ins, ctl(0,0,2'b00,1,2'b01,2'b00,0,0,3'b000,0,0,0,0), m_base, 0, 0, 0, 0);
    n_ret++;
  endtask

  task automatic do_imm(string tag, logic [31:0] ins, logic [2:0] alu);
    push_if(tag, ins, 0);
    push_id0(tag, ins, 0);
    push({tag, "_ex"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,alu,0,0,0,0), m_imm, 0, 0, 0, 0);
    push({tag, "_wb"}, ins, ctl(0,0,2'b00,1,2'b00,2'b00,0,0,3'b000,0,0,0,0), m_base, 0, 0, 0, 0);
    n_ret++;
  endtask

  // waits = not-ready MEM cycles before the last MEM cycle; ok = ready in that last cycle.
  task automatic do_mem(string tag, logic [31:0] ins, logic lw, int waits, logic ok, logic pre);
    push_if(tag, ins, pre);
    push_id0(tag, ins, pre);
    push({tag, "_ex"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,1,1,3'b000,0,0,0,0), m_all, 0, 0, pre, 0);
    for (int i = 0; i < waits; i++)
      push({tag, "_memw"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,1,1,3'b000,lw,!lw,0,0), m_all, 0, 0, 0, 0);
    if (ok)
      push({tag, "_memok"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,1,1,3'b000,lw,!lw,0,0), m_all, 0, 0, 1, 0);
    else
      push({tag, "_memto"}, ins, ctl(0,0,2'b00,0,2'b00,2'b00,1,1,3'b000,0,0,0,1), m_all, 0, 0, 0, 0);
    if (ok && lw)
      push({tag, "_wb"}, ins, ctl(0,0,2'b00,1,2'b00,2'b01,0,0,3'b000,0,0,0,0), m_base, 0, 0, 0, 0);
    if (ok) n_ret++;
  endtask

  task automatic do_beq(string tag, logic z);
    push_if(tag, 32'h10220003, !z);
    push({tag, "_id"}, 32'h10220003, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,0,0), m_base, 0, !z, 0, 0);
    push({tag, "_ex"}, 32'h10220003, ctl(z,0,2'b01,0,2'b00,2'b00,0,0,3'b001,0,0,0,0), m_all, 0, z, 0, 0);
    n_ret++;
  endtask

  task automatic do_id(string tag, logic [31:0] ins, ctl_t v, logic ret);
    push_if(tag, ins, 0);
    push({tag, "_id"}, ins, v, m_base, 0, 0, 0, 0);
    if (ret) n_ret++;
  endtask

  task automatic push_rst(string tag, logic [31:0] ins, logic chk);
    push(tag, ins, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,3'b100,0,0,0,0), m_all, 1, 0, 0, chk);
  endtask

  task automatic run_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.r;
      bus.ins = e.ins;
      bus.zero = e.z;
      bus.mem_ready = e.rdy;
      @(negedge clk);
      checks++;
      assert ((obs & e.msk) === (e.val & e.msk)) else begin
        errors++;
        $error("FAIL %s ctl observed=%h expected=%h", e.tag, obs & e.msk, e.val & e.msk);
      end
      if (e.chk) begin
        checks++;
        assert (bus.instret === 32'(e.n)) else begin
          errors++;
          $error("FAIL %s instret observed=%0d expected=%0d", e.tag, bus.instret, e.n);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    m_all  = '1;
    m_base = ctl(1,1,2'b11,1,2'b11,2'b11,0,0,3'b000,1,1,1,1);
    m_imm  = m_base | ctl(0,0,2'b00,0,2'b00,2'b00,1,0,3'b111,0,0,0,0);
    rst = 1'b1;
    rst_w = 1'b1;
    bus.ins = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bw.ins = 32'h08000000; bw.zero = 1'b0; bw.mem_ready = 1'b0;

    for (int i = 0; i < 3; i++) push_rst("reset", 32'h00221821, 1);
    do_r("addu", 32'h00221821, 3'b000);
    do_mem("lw_wait2", 32'h8C220004, 1, 2, 1, 1);
    do_beq("beq_z1", 1);
    do_beq("beq_z0", 0);
    do_id("jal", 32'h0C000010, ctl(1,0,2'b10,1,2'b10,2'b10,0,0,3'b000,0,0,0,0), 1);
    do_id("jr", 32'h03E00008, ctl(1,0,2'b11,0,2'b00,2'b00,0,0,3'b000,0,0,0,0), 1);
    do_mem("sw_timeout", 32'hAC220008, 0, 14, 0, 0);
    do_mem("sw_ready0", 32'hAC220008, 0, 0, 1, 0);
    do_mem("lw_tie", 32'h8C220004, 1, 14, 1, 0);
    do_id("ill_op", 32'hFC000000, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,1,0), 0);
    do_id("ill_fn", 32'h00000001, ctl(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,1,0), 0);
    do_imm("ori", 32'h34220005, 3'b010);
    do_imm("lui", 32'h3C011234, 3'b011);
    do_r("subu", 32'h00221823, 3'b001);
    do_r("or",   32'h00221825, 3'b010);
    do_r("and",  32'h00221824, 3'b110);
    do_r("slt",  32'h0022182A, 3'b101);
    // Reset in MEM of a load: nothing written, counter cleared.
    push_if("lw_abort", 32'h8C220004, 0);
    push_id0("lw_abort", 32'h8C220004, 0);
    push("lw_abort_ex", 32'h8C220004, ctl(0,0,2'b00,0,2'b00,2'b00,1,1,3'b000,0,0,0,0), m_all, 0, 0, 0, 0);
    push_rst("lw_abort_rst", 32'h8C220004, 0);
    n_ret = 0;
    do_id("j", 32'h08000000, ctl(1,0,2'b10,0,2'b00,2'b00,0,0,3'b000,0,0,0,0), 1);
    push_if("final", 32'h00221821, 0);
    run_sb();

    rst_w = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      checks++;
      assert (bw.instret === 4'(i % 16)) else begin
        errors++;
        $error("FAIL wrap_instret after %0d j: observed=%0d expected=%0d", i, bw.instret, i % 16);
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
